// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - drives a bouncing 1-bit line to a requested level, then holds it to settle
// BOUNCE_FIXED_GAP_EN: every gap is 2^(GAP_W-1) cycles and the LFSR is left out.
module bounce_gen #(
  parameter int          BOUNCES = 3,
  parameter int          GAP_W   = 4,
  parameter int          SETTLE  = 32,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic target,
  output logic bounce_out,
  output logic busy,
  output logic done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BOUNCE = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int             EW        = $clog2(2 * BOUNCES + 2);
  localparam logic [EW-1:0]  EDGE_LAST = EW'(2 * BOUNCES + 1);
  localparam logic [15:0]    SETTLE_LD = 16'(SETTLE);

  logic [1:0]      state_q, state_d;
  logic            tgt_q, tgt_d;
  logic            bounce_q, bounce_d;
  logic [EW-1:0]   edge_q, edge_d;
  logic [GAP_W:0]  gap_q, gap_d;
  logic [15:0]     settle_q, settle_d;
  logic [GAP_W:0]  gap_val;

`ifdef BOUNCE_FIXED_GAP_EN
  localparam logic [GAP_W:0] FIXED_GAP = (GAP_W + 1)'(2 ** (GAP_W - 1));
  assign gap_val = FIXED_GAP;
`else
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  // Galois right-shift form; a nonzero state can never step to zero.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED_EFF;
    else      lfsr_q <= lfsr_d;
  end

  assign gap_val = {1'b0, lfsr_q[GAP_W-1:0]} + (GAP_W + 1)'(1);
`endif

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    bounce_d = bounce_q;
    edge_d   = edge_q;
    gap_d    = gap_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          tgt_d = target;
          if (target == bounce_q) begin
            state_d = S_DONE;
          end else begin
            bounce_d = ~bounce_q;
            edge_d   = EW'(1);
            gap_d    = gap_val;
            if (EDGE_LAST == EW'(1)) begin
              state_d  = S_SETTLE;
              settle_d = SETTLE_LD;
            end else begin
              state_d = S_BOUNCE;
            end
          end
        end
      end
      S_BOUNCE: begin
        // A gap of g loaded at one edge places the next edge g cycles later.
        if (gap_q <= (GAP_W + 1)'(1)) begin
          bounce_d = ~bounce_q;
          edge_d   = edge_q + EW'(1);
          gap_d    = gap_val;
          if (edge_q + EW'(1) == EDGE_LAST) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_LD;
            edge_d   = '0;
          end
        end else begin
          gap_d = gap_q - (GAP_W + 1)'(1);
        end
      end
      S_SETTLE: begin
        bounce_d = tgt_q;
        if (settle_q <= 16'd1) state_d = S_DONE;
        else                   settle_d = settle_q - 16'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tgt_q    <= 1'b0;
      bounce_q <= 1'b0;
      edge_q   <= '0;
      gap_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      bounce_q <= bounce_d;
      edge_q   <= edge_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
    end
  end

  assign bounce_out = bounce_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - randomized bench for bounce_gen against an edge-schedule model
module tb_bounce_gen;

  localparam int          BOUNCES = 2;
  localparam int          GAP_W   = 4;
  localparam int          SETTLE  = 32;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic clk;
  logic rst;
  logic req;
  logic target;
  logic bounce_out;
  logic busy;
  logic done;

  int tests  = 0;
  int errors = 0;

  logic        m_level;
  logic [15:0] m_lfsr;

  bounce_gen #(
    .BOUNCES(BOUNCES),
    .GAP_W  (GAP_W),
    .SETTLE (SETTLE),
    .SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .target    (target),
    .bounce_out(bounce_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int d);
    logic [15:0] r = v;
    for (int i = 0; i < d; i++) r = lfsr_step(r);
    return r;
  endfunction

  function automatic int gap_of(input logic [15:0] v);
`ifdef BOUNCE_FIXED_GAP_EN
    return 1 << (GAP_W - 1);
`else
    return 1 + int'(v) % (1 << GAP_W);
`endif
  endfunction

  // Reference LFSR value that the design samples at the coming edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= (SEED == 16'h0000) ? 16'h0001 : SEED;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called between edges; the request is sampled at the next rising edge (offset 0).
  task automatic run_seq(input logic tgt, input bit spam, input int abort_at);
    int          edges[$];
    logic [15:0] v;
    int          off;
    int          end_off;
    int          cnt;
    logic        lvl;
    logic        prev;
    int          obs_edges;
    int          last_edge;
    int          dones;
    logic [2:0]  exp_v;

    v   = m_lfsr;
    off = 0;
    if (tgt != m_level) begin
      for (int k = 0; k <= 2 * BOUNCES; k++) begin
        edges.push_back(off);
        if (k < 2 * BOUNCES) begin
          int g;
          g   = gap_of(v);
          v   = lfsr_adv(v, g);
          off = off + g;
        end
      end
      end_off = off + SETTLE;
    end else begin
      end_off = 0;
    end

    req       = 1'b1;
    target    = tgt;
    prev      = m_level;
    obs_edges = 0;
    last_edge = -1;
    dones     = 0;
    for (int n = 0; n <= end_off + 1; n++) begin
      @(posedge clk);
      #1;
      cnt = 0;
      foreach (edges[i]) if (edges[i] <= n) cnt++;
      lvl   = m_level ^ cnt[0];
      exp_v = {lvl, (n <= end_off), (n == end_off)};
      check("trace", {bounce_out, busy, done}, exp_v);
      if (bounce_out !== prev) begin
        if (last_edge >= 0)
          check("gap_range", ((n - last_edge) >= 1 && (n - last_edge) <= (1 << GAP_W)), 1);
        obs_edges++;
        last_edge = n;
      end
      prev = bounce_out;
      if (done === 1'b1) dones++;
      if (n == abort_at) begin
        req = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_out", {bounce_out, busy, done}, 3'b000);
        m_level = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      req    = (spam && n <= end_off) ? 1'($urandom_range(0, 1)) : 1'b0;
      target = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    check("edge_count", obs_edges, (tgt != m_level) ? 2 * BOUNCES + 1 : 0);
    check("final_level", bounce_out, tgt);
    check("done_pulses", dones, 1);
    m_level = tgt;
  endtask

  initial begin
    rst     = 1'b0;
    req     = 1'b0;
    target  = 1'b0;
    m_level = 1'b0;
    #12;
    check("reset_out", {bounce_out, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    run_seq(1'b1, 1'b0, -1);
    run_seq(1'b1, 1'b0, -1);
    run_seq(1'b0, 1'b1, -1);
    run_seq(1'b0, 1'b0, -1);
    run_seq(1'b1, 1'b1, 20);
    check("post_reset_idle", {bounce_out, busy, done}, 3'b000);
    run_seq(1'b1, 1'b0, -1);
    run_seq(1'b0, 1'b1, -1);

    for (int i = 0; i < 400; i++) begin
      logic t;
      t = ($urandom_range(0, 3) == 0) ? m_level : ~m_level;
      run_seq(t, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
